// File: rtl/fft_addr_gen.sv
// In-place radix-2 DIT FFT butterfly address generator.
// Walks (stage s, butterfly k) one butterfly per accepted step and presents
// registered operand addresses, twiddle exponent and stage for the datapath.
module fft_addr_gen #(
    parameter  int N     = 8,
    localparam int LOG2N = $clog2(N),
    localparam int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1,
    localparam int KW    = LOG2N - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    output logic             busy,
    output logic             bf_vld,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [KW-1:0]    tw_idx,
    output logic [SW-1:0]    stage,
    output logic             last,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [KW-1:0] KMAX = '1;               // N/2-1
    localparam logic [SW-1:0] SMAX = SW'(LOG2N - 1);

    state_t           state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [KW-1:0]    k_q, k_d;
    logic             busy_q, busy_d;
    logic             bf_vld_q, bf_vld_d;
    logic [LOG2N-1:0] addr_a_q, addr_a_d;
    logic [LOG2N-1:0] addr_b_q, addr_b_d;
    logic [KW-1:0]    tw_q, tw_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic             last_q, last_d;
    logic             done_q, done_d;

    logic [LOG2N-1:0] span, pos, grp, a_calc, b_calc;
    logic [SW-1:0]    tw_sh;

    // Butterfly (s, k) geometry: span 2^s, group k>>s, position within group.
    always_comb begin
        span   = LOG2N'(1) << s_q;
        pos    = {1'b0, k_q} & (span - LOG2N'(1));
        grp    = {1'b0, k_q} >> s_q;
        a_calc = ((grp << 1) << s_q) | pos;
        b_calc = a_calc + span;
        tw_sh  = SMAX - s_q;
    end

    // Next state, counter advance and output register inputs.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        k_d      = k_q;
        busy_d   = busy_q;
        bf_vld_d = 1'b0;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        tw_d     = tw_q;
        stage_d  = stage_q;
        last_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    s_d     = '0;
                    k_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                // The cycle carrying the final butterfly ignores step and
                // hands over to DONE.
                if (last_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (step) begin
                    bf_vld_d = 1'b1;
                    addr_a_d = a_calc;
                    addr_b_d = b_calc;
                    tw_d     = KW'(pos << tw_sh);
                    stage_d  = s_q;
                    if (k_q == KMAX) begin
                        k_d = '0;
                        if (s_q == SMAX) last_d = 1'b1;
                        else             s_d    = s_q + SW'(1);
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters and output registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            s_q      <= '0;
            k_q      <= '0;
            busy_q   <= 1'b0;
            bf_vld_q <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
            stage_q  <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            k_q      <= k_d;
            busy_q   <= busy_d;
            bf_vld_q <= bf_vld_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
            stage_q  <= stage_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign bf_vld = bf_vld_q;
    assign addr_a = addr_a_q;
    assign addr_b = addr_b_q;
    assign tw_idx = tw_q;
    assign stage  = stage_q;
    assign last   = last_q;
    assign done   = done_q;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Bench for fft_addr_gen: butterfly order comes from a textbook DIT loop nest.
module tb_fft_addr_gen;
    localparam int N     = 8;
    localparam int LOG2N = $clog2(N);
    localparam int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int KW    = LOG2N - 1;
    localparam int NB    = (N / 2) * LOG2N;
    localparam int VW    = 4 + SW + KW + 2 * LOG2N;

    logic clk = 1'b0;
    logic rst, start, step;
    logic busy, bf_vld, last, done;
    logic [LOG2N-1:0] addr_a, addr_b;
    logic [KW-1:0]    tw_idx;
    logic [SW-1:0]    stage;

    always #5 clk = ~clk;

    fft_addr_gen #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .step(step),
        .busy(busy), .bf_vld(bf_vld), .addr_a(addr_a), .addr_b(addr_b),
        .tw_idx(tw_idx), .stage(stage), .last(last), .done(done)
    );

    logic [VW-1:0] obs;
    assign obs = {bf_vld, last, done, busy, stage, tw_idx, addr_a, addr_b};

    int ea[NB], eb[NB], etw[NB], es[NB];
    int checks = 0;
    int fails  = 0;

    // Classic in-place DIT loop nest: for each stage, walk groups of 2*span.
    task automatic build_model();
        int idx = 0;
        for (int s = 0; s < LOG2N; s++) begin
            int span = 1 << s;
            for (int j = 0; j < N; j += 2 * span)
                for (int p = 0; p < span; p++) begin
                    ea[idx]  = j + p;
                    eb[idx]  = j + p + span;
                    etw[idx] = p * (N / (2 * span));
                    es[idx]  = s;
                    idx++;
                end
        end
    endtask

    // Expected output vector for butterfly i, either presenting (vld) or held.
    function automatic logic [VW-1:0] exp_bf(int i, bit vld);
        logic l;
        l = vld && (i == NB - 1);
        return {vld, l, 1'b0, 1'b1, SW'(es[i]), KW'(etw[i]),
                LOG2N'(ea[i]), LOG2N'(eb[i])};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [VW-1:0] e;
        rst = 1'b1; start = 1'b0; step = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== '0) begin fails++; $display("FAIL reset_out got=%h exp=%h", obs, VW'(0)); end
        e = '0;
        for (int n = 0; n < 3; n++) begin
            step = 1'b1; tick(); step = 1'b0;
            checks++;
            if (obs !== e) begin fails++; $display("FAIL idle_step got=%h exp=%h", obs, e); end
        end
    endtask

    task automatic test_full_spaced();
        logic [VW-1:0] e;
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (busy !== 1'b1 || bf_vld !== 1'b0) begin
            fails++; $display("FAIL spaced_start busy=%b vld=%b exp busy=1 vld=0", busy, bf_vld);
        end
        for (int i = 0; i < NB; i++) begin
            step = 1'b1; tick(); step = 1'b0;
            e = exp_bf(i, 1'b1);
            checks++;
            if (obs !== e) begin fails++; $display("FAIL spaced_bf%0d got=%h exp=%h", i, obs, e); end
            if (i < NB - 1) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    e = exp_bf(i, 1'b0);
                    checks++;
                    if (obs !== e) begin fails++; $display("FAIL spaced_hold%0d got=%h exp=%h", i, obs, e); end
                end
            end
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bf_vld !== 1'b0) begin
            fails++; $display("FAIL spaced_done done=%b busy=%b vld=%b exp 1 0 0", done, busy, bf_vld);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL spaced_idle done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] e;
        start = 1'b1; tick(); start = 1'b0;
        step = 1'b1;
        for (int i = 0; i < NB; i++) begin
            tick();
            e = exp_bf(i, 1'b1);
            checks++;
            if (obs !== e) begin fails++; $display("FAIL b2b_bf%0d got=%h exp=%h", i, obs, e); end
        end
        // step kept high across the two trailing cycles must be ignored
        tick();
        e = exp_bf(NB - 1, 1'b0);
        e[VW-1 -: 4] = 4'b0010;
        checks++;
        if (obs !== e) begin fails++; $display("FAIL b2b_done got=%h exp=%h", obs, e); end
        tick();
        step = 1'b0;
        e[VW-1 -: 4] = 4'b0000;
        checks++;
        if (obs !== e) begin fails++; $display("FAIL b2b_idle got=%h exp=%h", obs, e); end
    endtask

    task automatic test_start_step_same();
        logic [VW-1:0] e;
        start = 1'b1; step = 1'b1; tick(); start = 1'b0; step = 1'b0;
        e = exp_bf(NB - 1, 1'b0);
        checks++;
        if (obs !== e) begin fails++; $display("FAIL same_cycle got=%h exp=%h", obs, e); end
        for (int i = 0; i < NB; i++) begin
            step = 1'b1; tick(); step = 1'b0;
            e = exp_bf(i, 1'b1);
            checks++;
            if (obs !== e) begin fails++; $display("FAIL same_bf%0d got=%h exp=%h", i, obs, e); end
        end
        tick();
        checks++;
        if (done !== 1'b1) begin fails++; $display("FAIL same_done got=%b exp=1", done); end
        tick();
    endtask

    task automatic test_start_mid_run();
        logic [VW-1:0] e;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (i == 6) begin
                start = 1'b1; tick(); start = 1'b0;
                e = exp_bf(5, 1'b0);
                checks++;
                if (obs !== e) begin fails++; $display("FAIL mid_start got=%h exp=%h", obs, e); end
            end
            step = 1'b1; tick(); step = 1'b0;
            e = exp_bf(i, 1'b1);
            checks++;
            if (obs !== e) begin fails++; $display("FAIL mid_bf%0d got=%h exp=%h", i, obs, e); end
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL mid_done done=%b busy=%b exp 1 0", done, busy);
        end
        tick();
    endtask

    task automatic test_random();
        logic [VW-1:0] e;
        int prev = NB - 1;
        for (int t = 0; t < 4; t++) begin
            start = 1'b1; tick(); start = 1'b0;
            for (int i = 0; i < NB; i++) begin
                int gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    start = 1'($urandom_range(0, 1));
                    tick();
                    e = exp_bf(prev, 1'b0);
                    checks++;
                    if (obs !== e) begin fails++; $display("FAIL rnd_gap%0d got=%h exp=%h", i, obs, e); end
                end
                start = 1'($urandom_range(0, 1));
                step = 1'b1; tick(); step = 1'b0;
                e = exp_bf(i, 1'b1);
                checks++;
                if (obs !== e) begin fails++; $display("FAIL rnd_bf%0d got=%h exp=%h", i, obs, e); end
                prev = i;
            end
            start = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
            tick();
            e = exp_bf(NB - 1, 1'b0);
            e[VW-1 -: 4] = 4'b0010;
            checks++;
            if (obs !== e) begin fails++; $display("FAIL rnd_done got=%h exp=%h", obs, e); end
            start = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
            tick();
            start = 1'b0; step = 1'b0;
            e[VW-1 -: 4] = 4'b0000;
            checks++;
            if (obs !== e) begin fails++; $display("FAIL rnd_idle got=%h exp=%h", obs, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] e;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step = 1'b1; tick(); step = 1'b0; tick();
        end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (obs !== '0) begin fails++; $display("FAIL rstmid_out got=%h exp=%h", obs, VW'(0)); end
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (obs !== '0) begin fails++; $display("FAIL rstmid_nodone got=%h exp=%h", obs, VW'(0)); end
        end
        start = 1'b1; tick(); start = 1'b0;
        e = '0; e[VW-4] = 1'b1;
        checks++;
        if (obs !== e) begin fails++; $display("FAIL rstmid_start got=%h exp=%h", obs, e); end
        for (int i = 0; i < NB; i++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            step = 1'b1; tick(); step = 1'b0;
            e = exp_bf(i, 1'b1);
            checks++;
            if (obs !== e) begin fails++; $display("FAIL rstmid_bf%0d got=%h exp=%h", i, obs, e); end
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL rstmid_done done=%b busy=%b exp 1 0", done, busy);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; step = 1'b0;
        build_model();
        test_reset();
        test_full_spaced();
        test_back_to_back();
        test_start_step_same();
        test_start_mid_run();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without finishing");
        $fatal(1);
    end
endmodule

// File: doc/fft_addr_gen.md
# fft_addr_gen

In-place radix-2 DIT FFT butterfly address generator. Sits directly downstream of the stage counter. Each `step` pulse is one butterfly slot from the counter's `vld` strobe. The block advances one butterfly per slot and presents registered memory read/write addresses, a twiddle index and the stage number for the butterfly datapath. One `start` runs all LOG2N stages over N bit-reversed samples, then the block reports `done`.

## Interface
- `N`, default 8: FFT size; power of two, ≥4. LOG2N = $clog2(N).
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: one-cycle pulse that begins a transform. Honoured only in IDLE.
- `step`, input, 1: butterfly-slot strobe from the stage counter. Honoured only in RUN.
- `busy`, output, 1: high while a transform is in progress.
- `bf_vld`, output, 1: one-cycle pulse. `addr_a`, `addr_b`, `tw_idx` and `stage` are valid during it.
- `addr_a`, output, LOG2N: upper butterfly operand address.
- `addr_b`, output, LOG2N: lower butterfly operand address.
- `tw_idx`, output, LOG2N-1: twiddle exponent k, meaning W_N^k.
- `stage`, output, max(1,$clog2(LOG2N)): current stage, 0..LOG2N-1.
- `last`, output, 1: high with the final `bf_vld` of the transform.
- `done`, output, 1: one-cycle pulse after the final butterfly.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `start` → RUN, with internal stage counter s=0 and butterfly counter k=0.
  - `step` is ignored.
- **RUN, on each `step`:**
  - Present butterfly (s, k), where span = 2^s, group = k>>s, pos = k & (span-1).
  - `addr_a` = group·2·span + pos.
  - `addr_b` = `addr_a` + span.
  - `tw_idx` = pos << (LOG2N-1-s).
  - `stage` = s.
  - Arithmetic is unsigned; no result exceeds N-1, so there is no overflow handling.
- **Advance after each butterfly:**
  - k increments.
  - At k = N/2-1, k wraps to 0 and s increments.
  - At s = LOG2N-1 and k = N/2-1, the butterfly is final: assert `last` and go to DONE.
- **RUN, no `step`:** all counters and outputs hold; `bf_vld` = 0.
- **DONE:** lasts one cycle with `done` = 1, then → IDLE.
- **`start` outside IDLE:** ignored in RUN and DONE. There is no restart or abort except `rst`.
- **`start` and `step` in the same IDLE cycle:** `start` is taken and `step` is dropped. The first butterfly needs a later `step`.
- **Total per transform:** (N/2)·LOG2N butterflies (12 for N=8).

## Timing
- **Reset:** `rst` high at an edge forces IDLE. All outputs and internal counters go to 0 on that edge. This applies mid-transform too; the partial transform is discarded and there is no `done`.
- **Registered outputs:** no combinational path from input to output.
- **`start`:** sampled at edge t → `busy` = 1 from t+1.
- **`step`:** sampled at edge t → `bf_vld` = 1 and the new address set during cycle t+1 (latency 1).
  - Address outputs hold their last value until the next `bf_vld`.
- **Back-to-back `step`s** on consecutive cycles are legal. They give consecutive `bf_vld` cycles, one per butterfly.
- **Final `step`** at edge t:
  - `bf_vld` = `last` = 1 during t+1.
  - `done` = 1 and `busy` = 0 during t+2.
  - IDLE from t+3, and `start` is accepted from the t+3 edge.
  - A `step` at t+1 or t+2 is ignored.
- **Fed by the 3-phase stage counter:** one butterfly every 3 cycles, so 36 cycles of butterflies for N=8.

## Test plan
- **Reset values:** assert `rst` for 2 cycles, then release → every output = 0, `busy` = 0. `step` pulses with no `start` give no `bf_vld`.
- **Full N=8 run, `step` every 3rd cycle:** expect 12 `bf_vld` pulses.
  - Stage 0, k=0: a=0, b=1, tw=0. Stage 0, k=3: a=6, b=7, tw=0.
  - Stage 1, k=1: a=1, b=3, tw=2. Stage 1, k=2: a=4, b=6, tw=0.
  - Stage 2, k=3: a=3, b=7, tw=3, `last` = 1.
  - `done` one cycle after that; `busy` low in the same cycle as `done`.
- **Back-to-back `step` for 12 cycles:** 12 consecutive `bf_vld` cycles with the same address sequence as above. `done` two cycles after the final `step`.
- **`start` and `step` in the same IDLE cycle:** no `bf_vld` the next cycle. The following `step` yields stage 0, k=0 (a=0, b=1).
- **`start` pulsed mid-RUN** (after butterfly 5): ignored; the sequence continues with butterfly 6, i.e. stage 1, k=1 (a=1, b=3, tw=2).
- **`rst` after butterfly 7, then `start`:** outputs go to 0 with no `done`. A new `start` restarts at stage 0, k=0, and the full 12-butterfly sequence completes.
